lsu_bus_adapter: RTL and testbench

- Load/store unit directly downstream of the single-cycle core.
- Consumes the core's data-memory side: effective address (ALU result), store data, 2-bit store size and load size code.
- Drives a req/gnt/rvalid data bus with byte enables, steers and extends load data into the core's `data_in`, and stalls the core while an access is outstanding.
- Flags misaligned accesses and bus timeouts.

---
 rtl/lsu_pkg.sv | 62 ++++++
 rtl/lsu_load_align.sv | 47 ++++
 rtl/lsu_bus_adapter.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_bus_adapter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store bus adapter.
//   - FSM state encoding
//   - mem_write and size_load code points from the core
//   - access-size classification and load-code helpers
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_B    = 2'b01,
    MW_H    = 2'b10,
    MW_W    = 2'b11
  } mem_write_e;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } size_load_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } acc_size_e;

  // Context latched at request time, used when the response returns
  typedef struct packed {
    logic       rd;
    logic [1:0] off;
    logic [2:0] size_load;
  } ld_ctx_t;

  // Undefined load codes carry no alignment constraint; they fail in DONE
  function automatic acc_size_e load_size(input logic [2:0] code);
    acc_size_e sz;
    case (code)
      LD_H, LD_HU: sz = SZ_H;
      LD_W:        sz = SZ_W;
      default:     sz = SZ_B;
    endcase
    return sz;
  endfunction

  function automatic logic load_code_ok(input logic [2:0] code);
    logic ok;
    case (code)
      LD_B, LD_H, LD_W, LD_BU, LD_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data steering: selects byte/half lane of the bus word and extends it.
// Ports:
//   word      - raw 32-bit read word from the bus
//   off       - byte offset of the access within the word
//   size_load - funct3 load code
//   data      - extended result (0 for undefined codes)
//   code_ok   - size_load is a defined load code
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  size_load,
  output logic [31:0] data,
  output logic        code_ok
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select
  always_comb begin
    byte_sel = word[7:0];
    case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
  end

  // Extension
  always_comb begin
    data    = '0;
    code_ok = load_code_ok(size_load);
    case (size_load)
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      LD_W:    data = word;
      LD_BU:   data = {24'd0, byte_sel};
      LD_HU:   data = {16'd0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Load/store adapter between the single-cycle core and a req/gnt/rvalid bus.
// Ports:
//   clk, reset          - clock, async active-low reset
//   addr, wdata         - effective address and store data from the core
//   mem_write           - 00 none, 01 SB, 10 SH, 11 SW (write beats read)
//   mem_read, size_load - load request and funct3 load code
//   rdata               - extended load data, valid in the DONE cycle
//   stall               - core hold (combinational)
//   err                 - one-cycle misalign / timeout / bad-code pulse (combinational)
//   bus_*               - registered request side, gnt/rvalid/rdata response side
module lsu_bus_adapter
  import lsu_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [1:0]    mem_write,
  input  logic          mem_read,
  input  logic [2:0]    size_load,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic          err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  lsu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q;
  ld_ctx_t       ctx_q;
  logic          done_err_q;

  logic          wr_acc, acc, misalign, timeout_hit;
  acc_size_e     acc_size;
  logic [3:0]    be_c;
  logic [DW-1:0] wdata_c;
  logic [31:0]   ld_data;
  logic          ld_ok;

  logic stall_c, err_c, start, respond, abort, drop_req;

  // Access classification, byte enables and store-lane replication
  always_comb begin
    wr_acc   = (mem_write != MW_NONE);
    acc      = wr_acc | mem_read;
    acc_size = load_size(size_load);
    be_c     = 4'b1111;
    wdata_c  = wdata;
    if (wr_acc) begin
      case (mem_write)
        MW_B: begin
          acc_size = SZ_B;
          be_c     = 4'b0001 << addr[1:0];
          wdata_c  = {4{wdata[7:0]}};
        end
        MW_H: begin
          acc_size = SZ_H;
          be_c     = 4'b0011 << addr[1:0];
          wdata_c  = {2{wdata[15:0]}};
        end
        default: begin
          acc_size = SZ_W;
          be_c     = 4'b1111;
          wdata_c  = wdata;
        end
      endcase
    end
    misalign = ((acc_size == SZ_H) && addr[0]) ||
               ((acc_size == SZ_W) && (addr[1:0] != 2'b00));
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // FSM next-state and control strobes
  always_comb begin
    state_d  = state_q;
    stall_c  = 1'b0;
    err_c    = 1'b0;
    start    = 1'b0;
    respond  = 1'b0;
    abort    = 1'b0;
    drop_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (misalign) begin
            err_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            start   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        if (bus_gnt && bus_rvalid) begin
          respond  = 1'b1;
          drop_req = 1'b1;
          state_d  = DONE;
        end else if (timeout_hit) begin
          abort    = 1'b1;
          drop_req = 1'b1;
          state_d  = DONE;
        end else if (bus_gnt) begin
          drop_req = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        if (bus_rvalid) begin
          respond = 1'b1;
          state_d = DONE;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        err_c   = done_err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs are forced low while reset is asserted
  assign stall = reset & stall_c;
  assign err   = reset & err_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Access timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if ((state_q == REQ) || (state_q == WAIT)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  lsu_load_align u_load_align (
    .word      (bus_rdata),
    .off       (ctx_q.off),
    .size_load (ctx_q.size_load),
    .data      (ld_data),
    .code_ok   (ld_ok)
  );

  // Request registers and response capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      rdata      <= '0;
      ctx_q      <= '0;
      done_err_q <= 1'b0;
    end else begin
      if (start) begin
        bus_req         <= 1'b1;
        bus_we          <= wr_acc;
        bus_addr        <= {addr[AW-1:2], 2'b00};
        bus_be          <= be_c;
        bus_wdata       <= wdata_c;
        ctx_q.rd        <= ~wr_acc;
        ctx_q.off       <= addr[1:0];
        ctx_q.size_load <= size_load;
      end else if (drop_req) begin
        bus_req <= 1'b0;
      end

      if (respond) begin
        rdata      <= (ctx_q.rd && ld_ok) ? DW'(ld_data) : '0;
        done_err_q <= ctx_q.rd & ~ld_ok;
      end else if (abort) begin
        rdata      <= '0;
        done_err_q <= 1'b1;
      end else if (state_q == DONE) begin
        rdata      <= '0;
        done_err_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// Directed bench for lsu_bus_adapter (TIMEOUT overridden to 4).
module tb_lsu_bus_adapter;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  mem_write;
  logic        mem_read;
  logic [2:0]  size_load;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int passed = 0;

  lsu_bus_adapter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .wdata      (wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .size_load  (size_load),
    .rdata      (rdata),
    .stall      (stall),
    .err        (err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Zero-wait load: IDLE detect, REQ with gnt+rvalid, DONE, then back to IDLE
  task automatic do_load_zw(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] rd,
                            output logic [3:0] stl, output logic [3:0] be,
                            output logic [31:0] ba, output logic [31:0] rdo, output logic eo);
    mem_read = 1'b1; addr = a; size_load = sz;
    @(negedge clk); stl[0] = stall;
    step(); bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = rd;
    @(negedge clk); stl[1] = stall; be = bus_be; ba = bus_addr;
    step(); bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk); stl[2] = stall; rdo = rdata; eo = err;
    step(); mem_read = 1'b0;
    @(negedge clk); stl[3] = stall;
    step();
  endtask

  task automatic test_reset;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) $display("FAIL reset_bus_req got=%0b exp=0", bus_req); else passed++;
    checks++; if (bus_we !== 1'b0) $display("FAIL reset_bus_we got=%0b exp=0", bus_we); else passed++;
    checks++; if (stall !== 1'b0 || err !== 1'b0) $display("FAIL reset_stall_err got=%0b%0b exp=00", stall, err); else passed++;
    checks++; if (bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0 || rdata !== 32'h0)
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", bus_addr, bus_be, bus_wdata, rdata); else passed++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_lb_zero_wait;
    logic [3:0] stl, be; logic [31:0] ba, rdo; logic eo;
    do_load_zw(32'h103, 3'b000, 32'h80FF_1234, stl, be, ba, rdo, eo);
    checks++; if (be !== 4'b1111) $display("FAIL lb_be got=%b exp=1111", be); else passed++;
    checks++; if (ba !== 32'h100) $display("FAIL lb_addr got=%h exp=00000100", ba); else passed++;
    checks++; if (rdo !== 32'hFFFF_FF80) $display("FAIL lb_rdata got=%h exp=ffffff80", rdo); else passed++;
    checks++; if (eo !== 1'b0) $display("FAIL lb_err got=%0b exp=0", eo); else passed++;
    checks++; if (stl !== 4'b0011) $display("FAIL lb_stall_seq got=%b exp=0011", stl); else passed++;
  endtask

  task automatic test_half_loads;
    logic [3:0] stl, be; logic [31:0] ba, rdo; logic eo;
    do_load_zw(32'h102, 3'b101, 32'h9ABC_0000, stl, be, ba, rdo, eo);
    checks++; if (rdo !== 32'h0000_9ABC) $display("FAIL lhu_rdata got=%h exp=00009abc", rdo); else passed++;
    do_load_zw(32'h102, 3'b001, 32'h9ABC_0000, stl, be, ba, rdo, eo);
    checks++; if (rdo !== 32'hFFFF_9ABC) $display("FAIL lh_rdata got=%h exp=ffff9abc", rdo); else passed++;
    checks++; if (stl !== 4'b0011) $display("FAIL lh_stall_seq got=%b exp=0011", stl); else passed++;
  endtask

  task automatic test_other_loads;
    logic [3:0] stl, be; logic [31:0] ba, rdo; logic eo;
    do_load_zw(32'h100, 3'b100, 32'h80FF_1234, stl, be, ba, rdo, eo);
    checks++; if (rdo !== 32'h0000_0034) $display("FAIL lbu_rdata got=%h exp=00000034", rdo); else passed++;
    do_load_zw(32'h104, 3'b010, 32'hCAFE_F00D, stl, be, ba, rdo, eo);
    checks++; if (rdo !== 32'hCAFE_F00D || ba !== 32'h104) $display("FAIL lw_rdata got=%h@%h exp=cafef00d@00000104", rdo, ba); else passed++;
    do_load_zw(32'h700, 3'b011, 32'h1234_5678, stl, be, ba, rdo, eo);
    checks++; if (rdo !== 32'h0 || eo !== 1'b1) $display("FAIL badcode got=%h err=%0b exp=00000000 err=1", rdo, eo); else passed++;
  endtask

  task automatic test_sb_stalled_grant;
    mem_write = 2'b01; addr = 32'h201; wdata = 32'h0000_00A5;
    @(negedge clk);
    checks++; if (stall !== 1'b1 || bus_req !== 1'b0) $display("FAIL sb_detect got=stall%0b req%0b exp=stall1 req0", stall, bus_req); else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_be !== 4'b0010 || bus_wdata !== 32'hA5A5_A5A5 || bus_addr !== 32'h200)
        $display("FAIL sb_hold%0d got=req%0b we%0b be%b wd%h a%h exp=req1 we1 be0010 wda5a5a5a5 a00000200",
                 i, bus_req, bus_we, bus_be, bus_wdata, bus_addr);
      else passed++;
    end
    step(); bus_gnt = 1'b1; bus_rvalid = 1'b1;
    @(negedge clk);
    step(); bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || bus_req !== 1'b0)
      $display("FAIL sb_done got=stall%0b err%0b rdata%h req%0b exp=0 0 0 0", stall, err, rdata, bus_req); else passed++;
    step(); mem_write = 2'b00;
    step();
  endtask

  task automatic test_misaligned;
    mem_write = 2'b11; addr = 32'h302; wdata = 32'h1111_2222;
    @(negedge clk);
    checks++; if (err !== 1'b1 || stall !== 1'b0 || rdata !== 32'h0)
      $display("FAIL sw_misalign got=err%0b stall%0b rdata%h exp=err1 stall0 rdata0", err, stall, rdata); else passed++;
    step(); mem_write = 2'b00; mem_read = 1'b1; size_load = 3'b001; addr = 32'h101;
    @(negedge clk);
    checks++; if (err !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0)
      $display("FAIL lh_misalign got=err%0b stall%0b req%0b exp=1 0 0", err, stall, bus_req); else passed++;
    step(); mem_read = 1'b0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0 || err !== 1'b0 || stall !== 1'b0)
      $display("FAIL misalign_idle got=req%0b err%0b stall%0b exp=0 0 0", bus_req, err, stall); else passed++;
    step();
  endtask

  task automatic test_timeout;
    int req_cycles;
    bit done_seen;
    req_cycles = 0;
    done_seen = 1'b0;
    mem_read = 1'b1; size_load = 3'b010; addr = 32'h600;
    @(negedge clk);
    for (int i = 0; i < 8 && !done_seen; i++) begin
      step();
      @(negedge clk);
      if (bus_req === 1'b1) req_cycles++;
      else done_seen = 1'b1;
    end
    checks++; if (req_cycles != 4) $display("FAIL timeout_req_cycles got=%0d exp=4", req_cycles); else passed++;
    checks++; if (err !== 1'b1 || rdata !== 32'h0 || stall !== 1'b0)
      $display("FAIL timeout_done got=err%0b rdata%h stall%0b exp=err1 rdata0 stall0", err, rdata, stall); else passed++;
    step(); mem_read = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    step(); bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    checks++; if (rdata !== 32'h0 || err !== 1'b0 || stall !== 1'b0 || bus_req !== 1'b0)
      $display("FAIL stray_rvalid got=rdata%h err%0b stall%0b req%0b exp=0 0 0 0", rdata, err, stall, bus_req); else passed++;
    step();
  endtask

  task automatic test_reset_in_wait;
    mem_read = 1'b1; size_load = 3'b010; addr = 32'h500;
    @(negedge clk);
    step(); bus_gnt = 1'b1;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) $display("FAIL rw_req got=%0b exp=1", bus_req); else passed++;
    step(); bus_gnt = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b1 || bus_req !== 1'b0) $display("FAIL rw_wait got=stall%0b req%0b exp=1 0", stall, bus_req); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || bus_req !== 1'b0 || err !== 1'b0)
      $display("FAIL rw_async got=stall%0b req%0b err%0b exp=0 0 0", stall, bus_req, err); else passed++;
    @(posedge clk); #2;
    reset = 1'b1; mem_read = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    step(); bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    checks++; if (rdata !== 32'h0 || err !== 1'b0 || stall !== 1'b0)
      $display("FAIL rw_after got=rdata%h err%0b stall%0b exp=0 0 0", rdata, err, stall); else passed++;
    // SH through REQ -> WAIT -> DONE after reset
    step(); mem_write = 2'b10; addr = 32'h400; wdata = 32'h1234_BEEF;
    @(negedge clk);
    checks++; if (stall !== 1'b1) $display("FAIL sh_detect got=%0b exp=1", stall); else passed++;
    step(); bus_gnt = 1'b1;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_be !== 4'b0011 || bus_wdata !== 32'hBEEF_BEEF || bus_addr !== 32'h400)
      $display("FAIL sh_req got=req%0b we%0b be%b wd%h a%h exp=1 1 0011 beefbeef 00000400",
               bus_req, bus_we, bus_be, bus_wdata, bus_addr); else passed++;
    step(); bus_gnt = 1'b0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0 || stall !== 1'b1) $display("FAIL sh_wait got=req%0b stall%0b exp=0 1", bus_req, stall); else passed++;
    step(); bus_rvalid = 1'b1;
    @(negedge clk);
    step(); bus_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || err !== 1'b0 || rdata !== 32'h0)
      $display("FAIL sh_done got=stall%0b err%0b rdata%h exp=0 0 0", stall, err, rdata); else passed++;
    step(); mem_write = 2'b00;
    step();
  endtask

  initial begin
    reset = 1'b0; addr = '0; wdata = '0; mem_write = 2'b00; mem_read = 1'b0;
    size_load = 3'b000; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    test_reset();
    test_lb_zero_wait();
    test_half_loads();
    test_other_loads();
    test_sb_stalled_grant();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
